// File: rtl/ldpc_iter_ctrl.sv
// Purpose  : sequences an LDPC decoder through VNU and CNU phases until the syndrome clears or MAX_ITER is reached.
// Latency  : one iteration = COLS+VNU_LAT + ROWS+CNU_LAT + 1 (or more while waiting for check_valid) cycles.
// Backpress: none on the pipelines; the FSM stalls in CHECK until check_valid, and start is ignored unless IDLE.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   start                   one-cycle request to decode a loaded codeword (honoured only in IDLE)
//   check_valid/syndrome_ok parity checker handshake; syndrome_ok sampled only with check_valid in CHECK
//   vnu_en/vnu_addr         VNU pipeline issue enable and column address
//   vnu_wr_en/vnu_wr_addr   VNU writeback strobe and address, VNU_LAT cycles behind issue
//   first_iter              high through the VNU phase of iteration 0 (zeroes CNU message inputs)
//   cnu_en/cnu_addr         CNU pipeline issue enable and row address
//   cnu_wr_en/cnu_wr_addr   CNU writeback strobe and address, CNU_LAT cycles behind issue
//   check_req               one-cycle request to the parity checker
//   busy/done               decode in progress / one-cycle completion pulse
//   converged/iter_count    result flag and completed iteration count, held until the next start
module ldpc_iter_ctrl #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int MAX_ITER = 10,
    parameter int VNU_LAT  = 2,
    parameter int CNU_LAT  = 2,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          check_valid,
    input  logic          syndrome_ok,
    output logic          vnu_en,
    output logic [AW-1:0] vnu_addr,
    output logic          vnu_wr_en,
    output logic [AW-1:0] vnu_wr_addr,
    output logic          first_iter,
    output logic          cnu_en,
    output logic          cnu_wr_en,
    output logic [AW-1:0] cnu_addr,
    output logic [AW-1:0] cnu_wr_addr,
    output logic          check_req,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [3:0]    iter_count
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_V_ISSUE = 3'd1;
    localparam logic [2:0] S_V_DRAIN = 3'd2;
    localparam logic [2:0] S_C_ISSUE = 3'd3;
    localparam logic [2:0] S_C_DRAIN = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    // Drain counter is shared by both phases, so it is sized for the longer pipe.
    localparam int MAX_LAT = (VNU_LAT > CNU_LAT) ? VNU_LAT : CNU_LAT;
    localparam int LW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [AW-1:0] LAST_COL   = AW'(COLS - 1);
    localparam logic [AW-1:0] LAST_ROW   = AW'(ROWS - 1);
    localparam logic [LW-1:0] V_LAST_LAT = LW'(VNU_LAT - 1);
    localparam logic [LW-1:0] C_LAST_LAT = LW'(CNU_LAT - 1);
    localparam logic [3:0]    ITER_LIMIT = 4'(MAX_ITER);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [2:0]    state_q,      state_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [LW-1:0] lat_q,        lat_d;
    logic          first_iter_q, first_iter_d;
    logic          converged_q,  converged_d;
    logic [3:0]    iter_q,       iter_d;
    logic          check_req_q,  check_req_d;

    logic [3:0]    iter_inc;

    // Saturating increment: iter_count may never wrap past MAX_ITER.
    assign iter_inc = (iter_q == ITER_LIMIT) ? iter_q : (iter_q + 4'd1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lat_d        = lat_q;
        first_iter_d = first_iter_q;
        converged_d  = converged_q;
        iter_d       = iter_q;
        check_req_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_d       = 4'd0;
                    converged_d  = 1'b0;
                    first_iter_d = 1'b1;
                    addr_d       = '0;
                    state_d      = S_V_ISSUE;
                end
            end

            S_V_ISSUE: begin
                if (addr_q == LAST_COL) begin
                    lat_d   = '0;
                    state_d = S_V_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            // Address stays parked on the last column while the pipe empties.
            S_V_DRAIN: begin
                if (lat_q == V_LAST_LAT) begin
                    addr_d       = '0;
                    first_iter_d = 1'b0;
                    state_d      = S_C_ISSUE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_C_ISSUE: begin
                if (addr_q == LAST_ROW) begin
                    lat_d   = '0;
                    state_d = S_C_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            // check_req is registered on the way into CHECK so it lands on
            // the first CHECK cycle exactly once.
            S_C_DRAIN: begin
                if (lat_q == C_LAST_LAT) begin
                    check_req_d = 1'b1;
                    state_d     = S_CHECK;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (check_valid) begin
                    iter_d = iter_inc;
                    if (syndrome_ok) begin
                        converged_d = 1'b1;
                        state_d     = S_FIN;
                    end else if (iter_inc == ITER_LIMIT) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = '0;
                        state_d = S_V_ISSUE;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            lat_q        <= '0;
            first_iter_q <= 1'b0;
            converged_q  <= 1'b0;
            iter_q       <= 4'd0;
            check_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lat_q        <= lat_d;
            first_iter_q <= first_iter_d;
            converged_q  <= converged_d;
            iter_q       <= iter_d;
            check_req_q  <= check_req_d;
        end
    end

    // ------------------------------------------------------------------
    // Issue-side outputs, decoded from state
    // ------------------------------------------------------------------
    logic v_phase, c_phase, v_issue, c_issue;

    assign v_issue = (state_q == S_V_ISSUE);
    assign c_issue = (state_q == S_C_ISSUE);
    assign v_phase = v_issue || (state_q == S_V_DRAIN);
    assign c_phase = c_issue || (state_q == S_C_DRAIN);

    assign vnu_en     = v_phase;
    assign vnu_addr   = v_phase ? addr_q : '0;
    assign cnu_en     = c_phase;
    assign cnu_addr   = c_phase ? addr_q : '0;
    assign first_iter = first_iter_q;
    assign check_req  = check_req_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done       = (state_q == S_FIN);
    assign converged  = converged_q;
    assign iter_count = iter_q;

    // ------------------------------------------------------------------
    // Writeback delay lines. Only issue cycles (not drain cycles) push a
    // valid bit, so each phase yields exactly COLS / ROWS writebacks.
    // Both lines sit under the async reset so an aborted decode cannot
    // leak stale strobes after reset is released.
    // ------------------------------------------------------------------
    logic [VNU_LAT-1:0]         vpipe_vld_q,  vpipe_vld_d;
    logic [VNU_LAT-1:0][AW-1:0] vpipe_addr_q, vpipe_addr_d;
    logic [CNU_LAT-1:0]         cpipe_vld_q,  cpipe_vld_d;
    logic [CNU_LAT-1:0][AW-1:0] cpipe_addr_q, cpipe_addr_d;

    always_comb begin
        vpipe_vld_d     = vpipe_vld_q;
        vpipe_addr_d    = vpipe_addr_q;
        vpipe_vld_d[0]  = v_issue;
        vpipe_addr_d[0] = vnu_addr;
        for (int i = 1; i < VNU_LAT; i++) begin
            vpipe_vld_d[i]  = vpipe_vld_q[i-1];
            vpipe_addr_d[i] = vpipe_addr_q[i-1];
        end
    end

    always_comb begin
        cpipe_vld_d     = cpipe_vld_q;
        cpipe_addr_d    = cpipe_addr_q;
        cpipe_vld_d[0]  = c_issue;
        cpipe_addr_d[0] = cnu_addr;
        for (int i = 1; i < CNU_LAT; i++) begin
            cpipe_vld_d[i]  = cpipe_vld_q[i-1];
            cpipe_addr_d[i] = cpipe_addr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_vld_q  <= '0;
            vpipe_addr_q <= '0;
            cpipe_vld_q  <= '0;
            cpipe_addr_q <= '0;
        end else begin
            vpipe_vld_q  <= vpipe_vld_d;
            vpipe_addr_q <= vpipe_addr_d;
            cpipe_vld_q  <= cpipe_vld_d;
            cpipe_addr_q <= cpipe_addr_d;
        end
    end

    assign vnu_wr_en   = vpipe_vld_q[VNU_LAT-1];
    assign vnu_wr_addr = vpipe_addr_q[VNU_LAT-1];
    assign cnu_wr_en   = cpipe_vld_q[CNU_LAT-1];
    assign cnu_wr_addr = cpipe_addr_q[CNU_LAT-1];

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_en_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(vnu_en && cnu_en));
    a_iter_bound:   assert property (@(posedge clk) disable iff (!rst_n) iter_count <= ITER_LIMIT);

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
module tb_ldpc_iter_ctrl;
    localparam int COLS     = 8;
    localparam int ROWS     = 4;
    localparam int MAX_ITER = 10;
    localparam int VNU_LAT  = 2;
    localparam int CNU_LAT  = 2;
    localparam int AW       = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          check_valid = 1'b0;
    logic          syndrome_ok = 1'b0;
    logic          vnu_en, vnu_wr_en, first_iter, cnu_en, cnu_wr_en;
    logic          check_req, busy, done, converged;
    logic [AW-1:0] vnu_addr, vnu_wr_addr, cnu_addr, cnu_wr_addr;
    logic [3:0]    iter_count;

    ldpc_iter_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .MAX_ITER(MAX_ITER),
        .VNU_LAT(VNU_LAT), .CNU_LAT(CNU_LAT), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .check_valid(check_valid), .syndrome_ok(syndrome_ok),
        .vnu_en(vnu_en), .vnu_addr(vnu_addr),
        .vnu_wr_en(vnu_wr_en), .vnu_wr_addr(vnu_wr_addr),
        .first_iter(first_iter),
        .cnu_en(cnu_en), .cnu_wr_en(cnu_wr_en),
        .cnu_addr(cnu_addr), .cnu_wr_addr(cnu_wr_addr),
        .check_req(check_req), .busy(busy), .done(done),
        .converged(converged), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    logic [24:0] all_outs;
    assign all_outs = {vnu_en, vnu_addr, vnu_wr_en, vnu_wr_addr, first_iter, cnu_en,
                       cnu_wr_en, cnu_addr, cnu_wr_addr, check_req, busy, done,
                       converged, iter_count};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int addr; int first; } en_t;
    typedef struct { int addr; int ofs;   } wr_t;
    typedef struct { int conv; int iters; } res_t;

    en_t  ven_q[$];
    en_t  cen_q[$];
    wr_t  vwr_q[$];
    wr_t  cwr_q[$];
    int   chk_q[$];
    res_t res_q[$];

    int exp_conv;
    int exp_iters;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        checks++;
        errors++;
        $display("FAIL %s occurred with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Reference model: a decode that sees syndrome_ok on check number ok_at
    // (0 or beyond MAX_ITER means never) runs n iterations; each iteration is
    // a full VNU sweep, a full CNU sweep and one checker request.
    task automatic model_push(input int ok_at);
        int n;
        bit conv;
        conv = (ok_at >= 1) && (ok_at <= MAX_ITER);
        n    = conv ? ok_at : MAX_ITER;
        for (int it = 0; it < n; it++) begin
            for (int i = 0; i < COLS + VNU_LAT; i++)
                ven_q.push_back('{(i < COLS) ? i : COLS - 1, (it == 0) ? 1 : 0});
            for (int i = 0; i < COLS; i++)
                vwr_q.push_back('{i, VNU_LAT + i});
            for (int i = 0; i < ROWS + CNU_LAT; i++)
                cen_q.push_back('{(i < ROWS) ? i : ROWS - 1, 0});
            for (int i = 0; i < ROWS; i++)
                cwr_q.push_back('{i, CNU_LAT + i});
            chk_q.push_back(it);
        end
        res_q.push_back('{conv ? 1 : 0, n});
        exp_conv  = conv ? 1 : 0;
        exp_iters = n;
    endtask

    task automatic flush_model();
        ven_q.delete(); cen_q.delete(); vwr_q.delete();
        cwr_q.delete(); chk_q.delete(); res_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever the DUT presents activity.
    // ------------------------------------------------------------------
    int   vstart = 0;
    int   cstart = 0;
    bit   vprev  = 1'b0;
    bit   cprev  = 1'b0;
    en_t  me;
    wr_t  mw;
    res_t mr;
    int   mc;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            vprev = 1'b0;
            cprev = 1'b0;
        end else begin
            if (vnu_en || cnu_en)
                chk("en_overlap", int'(vnu_en & cnu_en), 0);
            if (vnu_en) begin
                if (!vprev) vstart = cyc;
                if (ven_q.size() == 0) unexp("vnu_en");
                else begin
                    me = ven_q.pop_front();
                    chk("vnu_addr", int'(vnu_addr), me.addr);
                    chk("first_iter_v", int'(first_iter), me.first);
                end
            end
            if (cnu_en) begin
                if (!cprev) cstart = cyc;
                if (cen_q.size() == 0) unexp("cnu_en");
                else begin
                    me = cen_q.pop_front();
                    chk("cnu_addr", int'(cnu_addr), me.addr);
                    chk("first_iter_c", int'(first_iter), me.first);
                end
            end
            if (vnu_wr_en) begin
                if (vwr_q.size() == 0) unexp("vnu_wr_en");
                else begin
                    mw = vwr_q.pop_front();
                    chk("vnu_wr_addr", int'(vnu_wr_addr), mw.addr);
                    chk("vnu_wr_offset", cyc - vstart, mw.ofs);
                end
            end
            if (cnu_wr_en) begin
                if (cwr_q.size() == 0) unexp("cnu_wr_en");
                else begin
                    mw = cwr_q.pop_front();
                    chk("cnu_wr_addr", int'(cnu_wr_addr), mw.addr);
                    chk("cnu_wr_offset", cyc - cstart, mw.ofs);
                end
            end
            if (check_req) begin
                if (chk_q.size() == 0) unexp("check_req");
                else mc = chk_q.pop_front();
            end
            if (done) begin
                if (res_q.size() == 0) unexp("done");
                else begin
                    mr = res_q.pop_front();
                    chk("done_converged", int'(converged), mr.conv);
                    chk("done_iter_count", int'(iter_count), mr.iters);
                    chk("done_busy", int'(busy), 0);
                end
            end
            vprev = vnu_en;
            cprev = cnu_en;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one decode job. hold keeps check_valid high throughout;
    // poke pulses start inside V_ISSUE and on each check_req; abort_chk>0
    // pulses reset during the CNU phase after that many checks.
    // Entered and left on a negedge.
    // ------------------------------------------------------------------
    task automatic run_job(input int ok_at, input bit hold, input bit poke, input int abort_chk);
        int nchk = 0;
        int dly  = 0;
        int budget = 0;
        bit pend = 0, want = 0, fin = 0, poked_v = 0, aborted = 0;

        model_push(ok_at);
        start = 1'b1;
        if (hold) begin check_valid = 1'b1; syndrome_ok = 1'b1; end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("first_iter_after_start", int'(first_iter), 1);

        while (!fin) begin
            start = 1'b0;
            if (done) begin
                fin = 1'b1;
                check_valid = 1'b0;
                syndrome_ok = 1'b0;
            end else begin
                if (hold) begin
                    check_valid = 1'b1;
                    syndrome_ok = 1'b1;
                end else begin
                    check_valid = 1'b0;
                    syndrome_ok = 1'($urandom_range(0, 1));
                    if (!pend && $urandom_range(0, 3) == 0) check_valid = 1'b1;
                end
                if (check_req) begin
                    nchk++;
                    pend = 1'b1;
                    want = (nchk == ok_at);
                    dly  = hold ? 0 : $urandom_range(0, 3);
                    if (poke) start = 1'b1;
                end
                if (pend) begin
                    if (dly == 0) begin
                        check_valid = 1'b1;
                        syndrome_ok = want;
                        pend = 1'b0;
                    end else begin
                        dly--;
                        check_valid = 1'b0;
                    end
                end
                if (poke && !poked_v && vnu_en && nchk == 0 && int'(vnu_addr) == 3) begin
                    start = 1'b1;
                    poked_v = 1'b1;
                end
                if (abort_chk > 0 && nchk == abort_chk && cnu_en && int'(cnu_addr) == 1) begin
                    rst_n = 1'b0;
                    #1;
                    flush_model();
                    start = 1'b0;
                    check_valid = 1'b0;
                    chk("abort_outputs", int'(all_outs), 0);
                    @(negedge clk);
                    chk("abort_outputs_hold", int'(all_outs), 0);
                    rst_n = 1'b1;
                    repeat (20) @(negedge clk);
                    chk("abort_idle_busy", int'(busy), 0);
                    chk("abort_idle_iter", int'(iter_count), 0);
                    aborted = 1'b1;
                    fin = 1'b1;
                end
                if (!fin) begin
                    @(negedge clk);
                    budget++;
                    if (budget > 4000) begin
                        unexp("job_timeout_no_done");
                        fin = 1'b1;
                    end
                end
            end
        end

        if (!aborted) begin
            repeat (3) @(negedge clk);
            chk("converged_held", int'(converged), exp_conv);
            chk("iter_count_held", int'(iter_count), exp_iters);
            chk("busy_idle", int'(busy), 0);
        end
        chk("scoreboard_drained",
            ven_q.size() + cen_q.size() + vwr_q.size() + cwr_q.size() + chk_q.size() + res_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(all_outs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", int'(all_outs), 0);

        run_job(1, 1'b0, 1'b0, 0);   // converge on first check
        run_job(0, 1'b0, 1'b0, 0);   // never converges: MAX_ITER iterations
        run_job(3, 1'b0, 1'b0, 0);   // converge on third check
        run_job(2, 1'b0, 1'b1, 0);   // stray start pulses
        run_job(2, 1'b1, 1'b0, 0);   // check_valid held high throughout
        run_job(0, 1'b0, 1'b0, 2);   // reset during CNU phase of iteration 2
        run_job(1, 1'b0, 1'b0, 0);   // clean run after abort
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
